// File: rtl/neg_unit_scheduler_pkg.sv
// Shared definitions for the negation-unit scheduler.
//   state_e         : scheduler FSM encoding
//   DEF_NUM_REQ     : default requester count
//   DEF_DATA_WIDTH  : default operand width
//   MOST_NEG_8      : most-negative 8-bit two's-complement value
package neg_unit_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;

  localparam logic [7:0] MOST_NEG_8 = 8'h80;

endpackage

// File: rtl/neg_unit_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   last_grant  : index granted most recently (lowest priority this round)
//   grant       : one-hot grant, all zero when nothing is requested
//   grant_idx   : encoded index of the grant
//   grant_valid : high when any request is granted
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] cand;

  // Search upward from last_grant+1 with wrap; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned off = 1; off <= unsigned'(NUM_REQ); off++) begin
      cand = IDX_W'((32'(last_grant) + off) % unsigned'(NUM_REQ));
      if (!grant_valid && req[cand]) begin
        grant_valid  = 1'b1;
        grant[cand]  = 1'b1;
        grant_idx    = cand;
      end
    end
  end

endmodule

// File: rtl/neg_unit_scheduler.sv
// Time-shares one external combinational negation unit among NUM_REQ
// requesters. One operand is accepted at a time (round robin), held on
// unit_in for a settle window, and the unit's result is returned with the
// owning requester index over a valid/ready response channel.
//   CLK, RESET      : clock, asynchronous active-high reset
//   req_valid/ready : per-requester operand handshake (ready is one-hot)
//   req_data        : packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   unit_in/unit_out: connection to the shared negation unit
//   rsp_*           : response channel (result, owner index, overflow flag)
//   busy            : high whenever an operation is in flight
module neg_unit_scheduler
  import neg_unit_scheduler_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         unit_in,
  input  logic [DATA_WIDTH-1:0]         unit_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic                          rsp_ovf,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  // Width-generic most-negative value; the 8-bit case uses the shared constant.
  localparam logic [DATA_WIDTH-1:0] MOST_NEG =
    (DATA_WIDTH == 8) ? DATA_WIDTH'(MOST_NEG_8)
                      : {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [IDX_W-1:0]      id_q, id_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDX_W-1:0]      rsp_id_q, rsp_id_d;
  logic                  rsp_ovf_q, rsp_ovf_d;

  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_valid;

  // Arbitration only runs in IDLE; RESET also masks it so req_ready is
  // zero while reset is held.
  assign arb_req = (state_q == IDLE && !RESET) ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (arb_req),
    .last_grant  (last_grant_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_ovf_d    = rsp_ovf_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          op_d         = req_data[arb_idx*DATA_WIDTH +: DATA_WIDTH];
          id_d         = arb_idx;
          last_grant_d = arb_idx;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          rsp_data_d = unit_out;
          rsp_id_d   = id_q;
          rsp_ovf_d  = (op_q == MOST_NEG);
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      op_q         <= '0;
      id_q         <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cnt_q        <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  // op_q only changes on acceptance, so it is stable through ISSUE/SETTLE.
  assign unit_in   = op_q;
  assign req_ready = arb_grant;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_neg_unit_scheduler.sv
// Testbench for neg_unit_scheduler: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// transaction-level model of the scheduler.
module tb_neg_unit_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int SC = 1;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic [DW-1:0]      unit_in;
  logic [DW-1:0]      unit_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DW-1:0]      rsp_data;
  logic [1:0]         rsp_id;
  logic               rsp_ovf;
  logic               busy;
  logic [DW-1:0]      unit_mask;

  int n_tests = 0;
  int n_fail  = 0;

  neg_unit_scheduler #(
    .NUM_REQ       (NR),
    .DATA_WIDTH    (DW),
    .SETTLE_CYCLES (SC)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .unit_in   (unit_in),
    .unit_out  (unit_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  // Shared negation unit; the mask lets some phases prove that rsp_data is
  // really taken from unit_out.
  assign unit_out = (8'h00 - unit_in) ^ unit_mask;

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------
  bit           m_busy;
  int           m_age;
  int           m_id;
  int           m_last;
  int           pick;
  int           c;
  logic [DW-1:0] m_op;
  logic [DW-1:0] m_exp;
  logic [NR-1:0] exp_rdy;
  bit           exp_rv;

  initial begin
    m_busy = 0; m_age = 0; m_id = 0; m_last = NR - 1; m_op = '0; m_exp = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_unit_in",   32'(unit_in), 0);
        chk("rst_rsp_data",  32'(rsp_data), 0);
        chk("rst_rsp_id",    32'(rsp_id), 0);
        chk("rst_rsp_ovf",   32'(rsp_ovf), 0);
        m_busy = 0;
        m_last = NR - 1;
      end else begin
        exp_rv = m_busy && (m_age >= 2 + SC);
        pick = -1;
        if (!m_busy) begin
          for (int i = 1; i <= NR; i++) begin
            c = (m_last + i) % NR;
            if (pick < 0 && req_valid[c]) pick = c;
          end
        end
        exp_rdy = '0;
        if (pick >= 0) exp_rdy[pick] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("busy",      32'(busy), 32'(m_busy));
        if (m_busy && m_age >= 1 && m_age <= 1 + SC)
          chk("unit_in", 32'(unit_in), 32'(m_op));
        if (exp_rv) begin
          chk("rsp_data", 32'(rsp_data), 32'(m_exp));
          chk("rsp_id",   32'(rsp_id), m_id);
          chk("rsp_ovf",  32'(rsp_ovf), 32'(m_op == 8'h80));
        end
        if (m_busy) begin
          if (exp_rv && rsp_ready) m_busy = 0;
          else m_age++;
        end else if (pick >= 0) begin
          m_busy = 1;
          m_age  = 1;
          m_id   = pick;
          m_last = pick;
          m_op   = req_data[pick*DW +: DW];
          m_exp  = (8'h00 - m_op) ^ unit_mask;
        end
      end
    end
  end

  // ---------------- directed helpers --------------------------------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [DW-1:0] mask);
    RESET     = 1'b1;
    req_valid = '0;
    unit_mask = mask;
    step();
    RESET = 1'b0;
  endtask

  // One operation from requester idx with rsp_ready high; the operand is
  // overwritten right after acceptance.
  task automatic run_op(input int idx, input logic [DW-1:0] op,
                        input logic [DW-1:0] exp_d, input logic exp_ovf,
                        input string nm);
    bit got;
    int lat;
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_data[idx*DW +: DW] = op;
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (req_ready[idx]) begin got = 1; break; end
    end
    chk({nm, "_accept"}, 32'(got), 1);
    step();
    req_valid = '0;
    req_data[idx*DW +: DW] = 8'h33;
    got = 0;
    lat = 0;
    for (int i = 1; i < 20; i++) begin
      @(negedge CLK);
      if (i == 2) chk({nm, "_unit_in"}, 32'(unit_in), 32'(op));
      if (rsp_valid) begin lat = i; got = 1; break; end
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_data"}, 32'(rsp_data), 32'(exp_d));
    chk({nm, "_id"},   32'(rsp_id), idx);
    chk({nm, "_ovf"},  32'(rsp_ovf), 32'(exp_ovf));
    step();
  endtask

  // ---------------- stimulus ----------------------------------------------
  logic [DW-1:0] rr_exp_d [5];
  int            rr_exp_id [5];
  bit            got_rsp;

  initial begin
    RESET = 1'b1; req_valid = '1; req_data = '0; rsp_ready = 1'b0; unit_mask = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    req_valid = '0;

    run_op(0, 8'h05, 8'hFB, 1'b0, "single");
    run_op(0, 8'h00, 8'h00, 1'b0, "zero");
    run_op(1, 8'h80, 8'h80, 1'b1, "mostneg");
    run_op(2, 8'hFF, 8'h01, 1'b0, "minus1");
    run_op(3, 8'h7F, 8'h81, 1'b0, "maxpos");
    run_op(1, 8'h10, 8'hF0, 1'b0, "chg");

    // Reset in SETTLE abandons the operation
    req_valid = 4'b0001; req_data[7:0] = 8'h05; rsp_ready = 1'b1;
    got_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (req_ready[0]) begin got_rsp = 1; break; end
    end
    chk("midrst_accept", 32'(got_rsp), 1);
    step(); req_valid = '0;
    step();
    RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_busy",      32'(busy), 0);
    chk("midrst_rsp_data",  32'(rsp_data), 0);
    step(); step();
    RESET = 1'b0;
    run_op(2, 8'h40, 8'hC0, 1'b0, "postrst");

    // Round robin from reset with all requesters pending
    do_reset(8'h00);
    req_valid = '1;
    req_data  = {8'h04, 8'h03, 8'h02, 8'h01};
    rsp_ready = 1'b1;
    rr_exp_d  = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFF};
    rr_exp_id = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) begin
      got_rsp = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge CLK);
        if (rsp_valid) begin got_rsp = 1; break; end
      end
      chk("rr_rsp_seen", 32'(got_rsp), 1);
      chk("rr_id",   32'(rsp_id), rr_exp_id[k]);
      chk("rr_data", 32'(rsp_data), 32'(rr_exp_d[k]));
      step();
    end
    req_valid = '0;
    step(); step();

    // Backpressure in RESP
    req_valid = 4'b0001; req_data[7:0] = 8'h0A; rsp_ready = 1'b0;
    got_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (req_ready[0]) begin got_rsp = 1; break; end
    end
    chk("bp_accept", 32'(got_rsp), 1);
    step();
    req_valid = '1;
    got_rsp = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rsp_valid) begin got_rsp = 1; break; end
    end
    chk("bp_rsp_seen", 32'(got_rsp), 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 1);
      chk("bp_rsp_data",  32'(rsp_data), 32'h F6);
      chk("bp_req_ready", 32'(req_ready), 0);
      step();
      if (k == 4) begin rsp_ready = 1'b1; req_valid = '0; end
      @(negedge CLK);
    end
    step(); step();

    // Randomized phase; mask switches only while reset is held
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset(8'h5A);
      else if ($urandom_range(0, 249) == 0) do_reset(unit_mask);
      req_valid = NR'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int l = 0; l < NR; l++) begin
        case ($urandom_range(0, 5))
          0: req_data[l*DW +: DW] = 8'h80;
          1: req_data[l*DW +: DW] = 8'h00;
          2: req_data[l*DW +: DW] = 8'hFF;
          3: req_data[l*DW +: DW] = 8'h7F;
          default: req_data[l*DW +: DW] = 8'($urandom);
        endcase
      end
      step();
    end
    req_valid = '0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/neg_unit_scheduler.md
Name: neg_unit_scheduler

Overview:
- Shares one combinational two's-complement (negation) unit between NUM_REQ requesters, e.g. the ALU SUB path, the branch-offset path and the immediate path.
- Accepts one operand at a time under round-robin arbitration and drives it, held stable, into the shared unit.
- Waits a fixed settle window, captures the result and returns it with the requester ID over a valid/ready response channel.
- Sits between the control/datapath requesters and the shared negation unit in the processor datapath.

Parameters:
NUM_REQ, 4, number of requesters; minimum 2.
DATA_WIDTH, 8, operand and result width in bits.
SETTLE_CYCLES, 1, full clock cycles the unit input is held before the output is sampled; minimum 1.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET  input  1  asynchronous, active-high reset.
req_valid  input  NUM_REQ  per-requester operand valid.
req_data  input  NUM_REQ*DATA_WIDTH  packed operands; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
req_ready  output  NUM_REQ  one-hot accept; an operand transfers on valid&ready.
unit_in  output  DATA_WIDTH  operand driven to the shared negation unit.
unit_out  input  DATA_WIDTH  result returned from the shared negation unit.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response consumer ready.
rsp_data  output  DATA_WIDTH  negated operand.
rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the response.
rsp_ovf  output  1  set when the operand was the most-negative value (0x80 for 8 bits); the result equals the input in that case.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE; op_reg, unit_in, rsp_data, rsp_id and rsp_ovf go to 0; rsp_valid, busy and req_ready go to 0.
  - last_grant goes to NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE -> ISSUE -> SETTLE -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational: one-hot for the first asserted req_valid searching upward from last_grant+1 with wrap; all zero when no request is pending.
  - On a transfer, latch the operand into op_reg, record the winner index in id_reg and in last_grant, then go to ISSUE.
- ISSUE:
  - unit_in is driven from op_reg and held stable in this state and in SETTLE.
  - Load the settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - When the counter is 0: register rsp_data from unit_out, rsp_id from id_reg, and rsp_ovf from (op_reg == 1 followed by DATA_WIDTH-1 zeros). Go to RESP.
- RESP:
  - rsp_valid=1, and rsp_data, rsp_id and rsp_ovf are held stable until rsp_valid&rsp_ready.
  - On that handshake, go to IDLE with rsp_valid=0 on the next cycle.
- Latency: with SETTLE_CYCLES=1, rsp_valid rises 3 cycles after the accept edge.
  - Minimum issue interval is 4 cycles per operation.
  - No new request is accepted until the cycle after the response handshake.
- Fairness: after granting requester k, k has the lowest priority at the next arbitration, so no requester starves while it holds req_valid.
- Arithmetic: modulo 2^DATA_WIDTH.
  - 0 -> 0 with rsp_ovf=0.
  - 0x80 -> 0x80 with rsp_ovf=1.
  - The block never computes the negation itself; rsp_data always comes from unit_out.
- Boundary conditions:
  - req_valid dropped in IDLE before a transfer has no effect and no state change.
  - req_valid/req_data changes after acceptance do not disturb op_reg.
  - Simultaneous requests are resolved by round robin only.
  - rsp_ready held high through RESP gives a one-cycle rsp_valid pulse.
  - rsp_ready asserted outside RESP is ignored.
  - RESET asserted mid-operation abandons the operation with no response, and the next arbitration starts from requester 0.

Decomposition:
- Shared package holds:
  - the state encoding: IDLE=2'd0, ISSUE=2'd1, SETTLE=2'd2, RESP=2'd3;
  - DATA_WIDTH and NUM_REQ defaults;
  - the most-negative constant 8'h80.
- One natural sub-module, rr_arbiter. It takes a request vector and last_grant, and produces a one-hot grant and the encoded index. It is purely combinational and is reused for future shared datapath units.

Test Plan:
- Reset mid-SETTLE: no rsp_valid, busy=0, outputs 0; next request from requester 2 alone is granted.
- Single op: req0=0x05 with rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_data=0xFB, rsp_id=0, rsp_ovf=0.
- Boundary operands, each followed to its response:
  - 0x00 -> 0x00, rsp_ovf=0.
  - 0x80 -> 0x80, rsp_ovf=1.
  - 0xFF -> 0x01.
  - 0x7F -> 0x81.
- All four requesters valid continuously from reset -> grant order 0,1,2,3,0; operands 0x01..0x04 -> responses 0xFF, 0xFE, 0xFD, 0xFC with matching rsp_id.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data (0xF6 for operand 0x0A) stable; req_ready all 0 until the handshake.
- Operand change after accept: req1 accepted with 0x10, then req_data1 driven to 0x33 -> unit_in stays 0x10 and rsp_data=0xF0.
